// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM-backed slave.
interface axi_sram_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed SRAM; independent read and write FSMs.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter string       INIT_FILE  = ""
) (
  input logic              aclk,
  input logic              aresetn,
  axi_sram_slave_if.slave  bus
);
  localparam int unsigned AW    = ADDR_WIDTH - 2;
  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [0:0] {RdIdle, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;

  logic [31:0] mem [Depth];

  // Read channel state
  rd_state_e   rd_state_q;
  logic [AW-1:0] rd_addr_q, rd_next_addr, ar_word;
  logic [3:0]  rd_len_q, rd_beat_q;
  logic [1:0]  rd_burst_q;
  logic        arready_q, rvalid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;

  assign ar_word      = bus.araddr[ADDR_WIDTH-1:2];
  assign rd_next_addr = (rd_burst_q == 2'b00) ? rd_addr_q : rd_addr_q + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RdIdle;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_beat_q  <= '0;
      rd_burst_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rid_q      <= '0;
    end else begin
      unique case (rd_state_q)
        RdIdle: begin
          arready_q <= 1'b1;
          if (arready_q && bus.arvalid) begin
            rid_q      <= bus.arid;
            rd_addr_q  <= ar_word;
            rd_len_q   <= bus.arlen[3:0];
            rd_burst_q <= bus.arburst;
            rd_beat_q  <= '0;
            rdata_q    <= (bus.arburst == 2'b11) ? '0 : mem[ar_word];
            rresp_q    <= (bus.arburst == 2'b11) ? 2'b10 : 2'b00;
            rlast_q    <= (bus.arlen[3:0] == 4'd0);
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RdData;
          end
        end
        RdData: begin
          if (bus.rready) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              rresp_q    <= 2'b00;
              arready_q  <= 1'b1;
              rd_state_q <= RdIdle;
            end else begin
              // Sampled before this edge's write lands, giving read-first ordering.
              rd_addr_q <= rd_next_addr;
              rd_beat_q <= rd_beat_q + 4'd1;
              rdata_q   <= (rd_burst_q == 2'b11) ? '0 : mem[rd_next_addr];
              rlast_q   <= (rd_beat_q + 4'd1 == rd_len_q);
            end
          end
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  // Write channel state
  wr_state_e   wr_state_q;
  logic [AW-1:0] wr_addr_q, wr_next_addr;
  logic [3:0]  wr_len_q, wr_beat_q;
  logic [1:0]  wr_burst_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;
  logic        wr_at_len, mem_we;

  assign wr_next_addr = (wr_burst_q == 2'b00) ? wr_addr_q : wr_addr_q + 1'b1;
  assign wr_at_len    = (wr_beat_q == wr_len_q);
  assign mem_we       = (wr_state_q == WrData) && wready_q && bus.wvalid && (wr_burst_q != 2'b11);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WrIdle;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_beat_q  <= '0;
      wr_burst_q <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
    end else begin
      unique case (wr_state_q)
        WrIdle: begin
          awready_q <= 1'b1;
          if (awready_q && bus.awvalid) begin
            bid_q      <= bus.awid;
            wr_addr_q  <= bus.awaddr[ADDR_WIDTH-1:2];
            wr_len_q   <= bus.awlen[3:0];
            wr_burst_q <= bus.awburst;
            wr_beat_q  <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= WrData;
          end
        end
        WrData: begin
          if (bus.wvalid) begin
            if (wr_at_len || bus.wlast) begin
              // Early or late wlast still completes, but is flagged.
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (wr_burst_q == 2'b11 || (wr_at_len != bus.wlast)) ? 2'b10 : 2'b00;
              wr_state_q <= WrResp;
            end else begin
              wr_addr_q <= wr_next_addr;
              wr_beat_q <= wr_beat_q + 4'd1;
            end
          end
        end
        WrResp: begin
          if (bus.bready) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            awready_q  <= 1'b1;
            wr_state_q <= WrIdle;
          end
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[wr_addr_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;

  logic unused_sigs;
  assign unused_sigs = ^{bus.awsize, bus.awlock, bus.awcache, bus.awprot, bus.arsize,
                         bus.arlock, bus.arcache, bus.arprot, bus.wid, bus.awlen[7:4],
                         bus.arlen[7:4], bus.awaddr[31:ADDR_WIDTH], bus.awaddr[1:0],
                         bus.araddr[31:ADDR_WIDTH], bus.araddr[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, stalls, error bursts and reset.
module tb_axi_sram_slave;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] wd [16];
  logic [31:0] ed [16];
  logic [1:0]  resp;

  axi_sram_slave_if bus ();

  axi_sram_slave #(.ADDR_WIDTH(16)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input int len, input logic [1:0] burst,
                    input int nbeats, input int last_idx, input logic [3:0] strb,
                    input logic [3:0] id, output logic [1:0] r);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst;
    bus.awsize = 3'b010; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) check("aw_timeout", 32'd1, 32'd0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = (i == last_idx);
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge aclk); #1; n++; end
      if (n >= 50) check("w_timeout", 32'd1, 32'd0);
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_after_last", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) check("b_timeout", 32'd1, 32'd0);
    r = bus.bresp;
    check("bid", 32'(bus.bid), 32'(id));
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [1:0] burst,
                    input logic [3:0] id, input int stall_beat, input logic [1:0] exp_resp);
    int n, beat, cyc;
    bit stalled;
    bus.rready = 1'b1;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst;
    bus.arsize = 3'b010; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) check("ar_timeout", 32'd1, 32'd0);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    check("rvalid_latency", 32'(bus.rvalid), 32'd1);
    beat = 0; cyc = 0; stalled = 1'b0;
    while (beat <= len && cyc < 100) begin
      cyc++;
      if (!bus.rvalid) begin @(posedge aclk); #1; continue; end
      if (beat == stall_beat && !stalled) begin
        bus.rready = 1'b0;
        @(posedge aclk); #1;
        check("stall_rvalid", 32'(bus.rvalid), 32'd1);
        check("stall_rdata", bus.rdata, ed[beat]);
        check("stall_rlast", 32'(bus.rlast), 32'(beat == len));
        bus.rready = 1'b1;
        stalled = 1'b1;
        continue;
      end
      check("rdata", bus.rdata, ed[beat]);
      check("rlast", 32'(bus.rlast), 32'(beat == len));
      check("rresp", 32'(bus.rresp), 32'(exp_resp));
      check("rid", 32'(bus.rid), 32'(id));
      @(posedge aclk); #1;
      beat++;
    end
    if (beat <= len) check("r_timeout", 32'd0, 32'd1);
    check("rvalid_end", 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = 2'b01;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset state and release
    repeat (2) @(posedge aclk);
    #1;
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_outs", {bus.rlast, bus.rresp, bus.bresp, bus.rid, bus.bid}, 32'd0);
    aresetn = 1'b1;
    #1;
    check("rel_arready_pre", 32'(bus.arready), 32'd0);
    @(posedge aclk); #1;
    check("rel_arready", 32'(bus.arready), 32'd1);
    check("rel_awready", 32'(bus.awready), 32'd1);
    check("rel_rvalid", 32'(bus.rvalid), 32'd0);
    check("rel_bvalid", 32'(bus.bvalid), 32'd0);

    // INCR write and read back
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    wr(32'h100, 3, 2'b01, 4, 3, 4'hF, 4'd5, resp);
    check("incr_bresp", 32'(resp), 32'd0);
    ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hA2; ed[3] = 32'hA3;
    rd(32'h100, 3, 2'b01, 4'd3, -1, 2'b00);

    // Byte strobes
    wd[0] = 32'hFFFF_FFFF;
    wr(32'h200, 0, 2'b01, 1, 0, 4'hF, 4'd1, resp);
    wd[0] = 32'h1122_3344;
    wr(32'h200, 0, 2'b01, 1, 0, 4'b0101, 4'd2, resp);
    ed[0] = 32'hFF22_FF44;
    rd(32'h200, 0, 2'b01, 4'd4, -1, 2'b00);

    // FIXED read returns the same word
    ed[0] = 32'hA1; ed[1] = 32'hA1; ed[2] = 32'hA1;
    rd(32'h104, 2, 2'b00, 4'd6, -1, 2'b00);

    // rready stall on beat 2
    ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hA2; ed[3] = 32'hA3;
    rd(32'h100, 3, 2'b01, 4'd7, 1, 2'b00);

    // Reserved awburst: error, no write
    wd[0] = 32'hDEAD_BEEF;
    wr(32'h100, 0, 2'b11, 1, 0, 4'hF, 4'd8, resp);
    check("awburst11_bresp", 32'(resp), 32'd2);
    ed[0] = 32'hA0;
    rd(32'h100, 0, 2'b01, 4'd9, -1, 2'b00);

    // Early wlast on beat 2 of 4
    wd[0] = 32'hB0; wd[1] = 32'hB1;
    wr(32'h300, 3, 2'b01, 2, 1, 4'hF, 4'd10, resp);
    check("early_wlast_bresp", 32'(resp), 32'd2);
    ed[0] = 32'hB0; ed[1] = 32'hB1;
    rd(32'h300, 1, 2'b01, 4'd11, -1, 2'b00);

    // Reserved arburst: SLVERR and zero data on every beat
    ed[0] = 32'h0; ed[1] = 32'h0;
    rd(32'h100, 1, 2'b11, 4'd12, -1, 2'b10);

    // INCR wraps at the top word; upper address bits alias
    wd[0] = 32'hC0; wd[1] = 32'hC1;
    wr(32'hFFFC, 1, 2'b01, 2, 1, 4'hF, 4'd13, resp);
    check("wrap_bresp", 32'(resp), 32'd0);
    ed[0] = 32'hC1;
    rd(32'h0, 0, 2'b01, 4'd14, -1, 2'b00);
    ed[0] = 32'hA0;
    rd(32'h1_0100, 0, 2'b01, 4'd15, -1, 2'b00);

    // Reset in the middle of a 4-beat read
    bus.rready = 1'b1;
    bus.arid = 4'd2; bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    check("mid_beat0", bus.rdata, 32'hA0);
    @(posedge aclk); #1;
    check("mid_beat1", bus.rdata, 32'hA1);
    #3;
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("mid_rst_rlast", 32'(bus.rlast), 32'd0);
    check("mid_rst_arready", 32'(bus.arready), 32'd0);
    #10;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_arready", 32'(bus.arready), 32'd1);
    check("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    ed[0] = 32'hA1;
    rd(32'h104, 0, 2'b01, 4'd3, -1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
